// File: rtl/dm_1k_pkg.sv
// dm_1k_pkg: shared constants and address helper for the 1 KiB data memory.
//   MEM_BYTES       - number of byte locations
//   BYTES_PER_WORD  - bytes covered by one access
//   lane_wrap()     - byte address of lane k, wrapped modulo the memory size
package dm_1k_pkg;

    localparam int ADDR_BITS      = 10;
    localparam int MEM_BYTES      = 1 << ADDR_BITS;
    localparam int BYTES_PER_WORD = 4;

    // Truncation to ADDR_BITS gives the modulo-1024 wrap for free.
    function automatic logic [ADDR_BITS-1:0] lane_wrap(
        input logic [ADDR_BITS-1:0] base,
        input int                   lane
    );
        return base + ADDR_BITS'(lane);
    endfunction

endpackage

// File: rtl/dm_byte_lane_addr.sv
// dm_byte_lane_addr: produces the four wrapped byte addresses touched by a
// word access starting at addr (lane 0 = least-significant byte).
//   addr       in   base byte address
//   lane_addr  out  per-lane byte addresses, addr+k modulo memory size
module dm_byte_lane_addr
    import dm_1k_pkg::*;
(
    input  logic [ADDR_BITS-1:0]                     addr,
    output logic [BYTES_PER_WORD-1:0][ADDR_BITS-1:0] lane_addr
);

    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
        assign lane_addr[k] = lane_wrap(addr, k);
    end

endmodule

// File: rtl/dm_1k.sv
// dm_1k: 1 KiB byte-addressed data memory for the MEM stage.
// Each access covers 4 consecutive bytes (little-endian, any alignment,
// wrapping at the top of memory). Reads are combinational, writes commit on
// the rising edge. Synchronous active-low reset clears every byte.
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (clears memory, beats WriteEn)
//   addr     in   byte address of the least-significant byte
//   din      in   write data
//   WriteEn  in   write din at addr on the next rising edge
//   dout     out  read data, combinational from addr and memory
module dm_1k
    import dm_1k_pkg::*;
#(
    parameter int ADDR_W = ADDR_BITS,
    parameter int DATA_W = 8 * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              WriteEn,
    output logic [DATA_W-1:0] dout
);

    logic [7:0] mem [MEM_BYTES];
    logic [BYTES_PER_WORD-1:0][ADDR_BITS-1:0] lane_addr;

    dm_byte_lane_addr u_lane_addr (
        .addr      (addr),
        .lane_addr (lane_addr)
    );

    // Full clear on reset so unwritten bytes never read back as X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (WriteEn) begin
            for (int k = 0; k < BYTES_PER_WORD; k++)
                mem[lane_addr[k]] <= din[8*k +: 8];
        end
    end

    // No write bypass: dout reflects stored contents only.
    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_rd
        assign dout[8*k +: 8] = mem[lane_addr[k]];
    end

endmodule

// File: tb/tb_dm_1k.sv
module tb_dm_1k;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        WriteEn;
    logic [31:0] dout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    dm_1k dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .din     (din),
        .WriteEn (WriteEn),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit past it before anything is
    // sampled or driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] addrs [3] = '{10'd0, 10'd100, 10'd1020};
        rst_n = 1'b0; WriteEn = 1'b0; din = 32'h0; addr = 10'd0;
        tick();
        rst_n = 1'b1;
        foreach (addrs[i]) begin
            addr = addrs[i]; #1;
            cmp_cnt++;
            if (dout !== 32'h0) begin
                err_cnt++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", addrs[i], dout, 32'h0);
            end
        end
    endtask

    task automatic test_aligned();
        addr = 10'd0; din = 32'h12345678; WriteEn = 1'b1;
        tick();
        WriteEn = 1'b0; din = 32'h0; #1;
        cmp_cnt++;
        if (dout !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL aligned_read got=%h exp=%h", dout, 32'h12345678);
        end
    endtask

    task automatic test_unaligned_read();
        WriteEn = 1'b0; din = 32'h0; addr = 10'd0;
        tick();
        addr = 10'd1; #1;
        cmp_cnt++;
        if (dout !== 32'h00123456) begin
            err_cnt++;
            $display("FAIL unaligned_read got=%h exp=%h", dout, 32'h00123456);
        end
        // Non-zero din with WriteEn low must also leave memory untouched.
        addr = 10'd0; din = 32'hDEADBEEF;
        tick();
        din = 32'h0; #1;
        cmp_cnt++;
        if (dout !== 32'h12345678) begin
            err_cnt++;
            $display("FAIL write_disabled got=%h exp=%h", dout, 32'h12345678);
        end
    endtask

    task automatic test_unaligned_write();
        addr = 10'd6; din = 32'hAABBCCDD; WriteEn = 1'b1;
        tick();
        WriteEn = 1'b0;
        addr = 10'd4; #1;
        cmp_cnt++;
        if (dout !== 32'hCCDD0000) begin
            err_cnt++;
            $display("FAIL unaligned_wr_a4 got=%h exp=%h", dout, 32'hCCDD0000);
        end
        addr = 10'd8; #1;
        cmp_cnt++;
        if (dout !== 32'h0000AABB) begin
            err_cnt++;
            $display("FAIL unaligned_wr_a8 got=%h exp=%h", dout, 32'h0000AABB);
        end
        addr = 10'd6; #1;
        cmp_cnt++;
        if (dout !== 32'hAABBCCDD) begin
            err_cnt++;
            $display("FAIL unaligned_wr_a6 got=%h exp=%h", dout, 32'hAABBCCDD);
        end
    endtask

    task automatic test_wrap();
        logic [9:0]  a_tab [4] = '{10'd1022, 10'd0, 10'd1021, 10'd1023};
        logic [31:0] e_tab [4] = '{32'h11223344, 32'h00001122, 32'h22334400, 32'h00112233};
        // Clean memory so bytes 2..3 are known zero.
        rst_n = 1'b0; WriteEn = 1'b0;
        tick();
        rst_n = 1'b1;
        addr = 10'd1022; din = 32'h11223344; WriteEn = 1'b1;
        tick();
        WriteEn = 1'b0;
        foreach (a_tab[i]) begin
            addr = a_tab[i]; #1;
            cmp_cnt++;
            if (dout !== e_tab[i]) begin
                err_cnt++;
                $display("FAIL wrap_read addr=%0d got=%h exp=%h", a_tab[i], dout, e_tab[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        addr = 10'd200; din = 32'hCAFEF00D; WriteEn = 1'b1; #1;
        cmp_cnt++;
        if (dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL rdw_before_edge got=%h exp=%h", dout, 32'h0);
        end
        tick();
        WriteEn = 1'b0;
        cmp_cnt++;
        if (dout !== 32'hCAFEF00D) begin
            err_cnt++;
            $display("FAIL rdw_after_edge got=%h exp=%h", dout, 32'hCAFEF00D);
        end
        // Back-to-back overlapping write at 202 replaces the upper half.
        addr = 10'd202; din = 32'h99887766; WriteEn = 1'b1;
        tick();
        WriteEn = 1'b0; addr = 10'd200; #1;
        cmp_cnt++;
        if (dout !== 32'h7766F00D) begin
            err_cnt++;
            $display("FAIL b2b_overlap got=%h exp=%h", dout, 32'h7766F00D);
        end
    endtask

    task automatic test_reset_priority();
        addr = 10'd0; din = 32'h55AA55AA; WriteEn = 1'b1;
        tick();
        rst_n = 1'b0; addr = 10'd0; din = 32'hFFFFFFFF; WriteEn = 1'b1;
        tick();
        rst_n = 1'b1; WriteEn = 1'b0; #1;
        cmp_cnt++;
        if (dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_priority got=%h exp=%h", dout, 32'h0);
        end
        addr = 10'd200; #1;
        cmp_cnt++;
        if (dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_clears_200 got=%h exp=%h", dout, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned_read();
        test_unaligned_write();
        test_wrap();
        test_read_during_write();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
